// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
//
// Purpose: multi-cycle instruction sequencer. It fetches one instruction at a
// time from instruction memory, decodes the opcode and then does one of three
// things with it. A branch redirects or advances pc straight away. An ALU
// operation starts the ALU, waits for its result (optionally latching the
// flags) and then writes back. The halt opcode parks the block until reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        begin execution (only looked at in IDLE)
//   imemReq      fetch request, high for the whole FETCH state
//   imemAddr     fetch address (always equal to pc)
//   imemAck      fetch data valid on instr
//   instr        fetched instruction, opcode in [31:26]
//   pc, ir       program counter and instruction register
//   aluStart     one-cycle ALU launch pulse
//   aluValid     ALU result/flags valid
//   aluZero/aluSign/aluCarry  ALU flags, qualified by aluValid
//   flagUpdate   current ALU instruction writes the flags
//   brTarget     branch target from datapath, valid in DECODE
//   regWrite     one-cycle register-file write strobe
//   branchTaken  one-cycle pulse when a branch redirects pc
//   halted       high while in HALT
// -----------------------------------------------------------------------------
module branch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        aluStart,
  input  logic        aluValid,
  input  logic        aluZero,
  input  logic        aluSign,
  input  logic        aluCarry,
  input  logic        flagUpdate,
  input  logic [31:0] brTarget,
  output logic        regWrite,
  output logic        branchTaken,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        flagZ_q, flagZ_d;
  logic        flagS_q, flagS_d;
  logic        flagC_q, flagC_d;

  logic [5:0]  opcode;
  logic        isHalt;
  logic        isBranch;
  logic        condTrue;

  // Branch targets are forced word-aligned, so the low two bits never matter.
  logic        unusedBrLow;
  assign unusedBrLow = ^brTarget[1:0];

  assign opcode = ir_q[31:26];
  assign isHalt = (opcode == 6'b111111);

  // Branch decode. Conditions look only at the registered flags, so a flag
  // change reaches a branch only after its ALU instruction has completed.
  always_comb begin
    isBranch = 1'b1;
    condTrue = 1'b0;
    case (opcode)
      6'b101011,
      6'b101000: condTrue = 1'b1;
      6'b110001: condTrue = flagZ_q;
      6'b110010: condTrue = ~flagZ_q;
      6'b110000: condTrue = flagS_q;
      6'b101001: condTrue = flagC_q;
      6'b101010: condTrue = ~flagC_q;
      default:   isBranch = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = FETCH;
      FETCH:   if (imemAck) state_d = DECODE;
      DECODE: begin
        if (isHalt)        state_d = HALT;
        else if (isBranch) state_d = FETCH;
        else               state_d = EXEC;
      end
      EXEC:    if (aluValid) state_d = WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only; reset clears state, so imemReq
  // drops the moment rst goes low.
  always_comb begin
    imemReq     = (state_q == FETCH);
    aluStart    = (state_q == DECODE) && !isHalt && !isBranch;
    branchTaken = (state_q == DECODE) && isBranch && condTrue;
    regWrite    = (state_q == WB);
    halted      = (state_q == HALT);
  end

  // Datapath next values. pc wraps naturally through 32-bit addition.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flagZ_d = flagZ_q;
    flagS_d = flagS_q;
    flagC_d = flagC_q;
    case (state_q)
      FETCH: if (imemAck) ir_d = instr;
      DECODE: begin
        if (isBranch) pc_d = condTrue ? {brTarget[31:2], 2'b00} : pc_q + 32'd4;
      end
      EXEC: begin
        if (aluValid && flagUpdate) begin
          flagZ_d = aluZero;
          flagS_d = aluSign;
          flagC_d = aluCarry;
        end
      end
      WB:      pc_d = pc_q + 32'd4;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= 32'd0;
      ir_q    <= 32'd0;
      flagZ_q <= 1'b0;
      flagS_q <= 1'b0;
      flagC_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flagZ_q <= flagZ_d;
      flagS_q <= flagS_d;
      flagC_q <= flagC_d;
    end
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign imemAddr = pc_q;

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  active-low reset; asserting it clears the block asynchronously.
REQ-004 start  input  1  begin execution; sampled in IDLE only.
REQ-005 imemReq  output  1  instruction-fetch request, level.
REQ-006 imemAddr  output  32  fetch address, equal to pc.
REQ-007 imemAck  input  1  fetch data valid on instr this cycle.
REQ-008 instr  input  32  fetched instruction; opcode is instr[31:26].
REQ-009 pc  output  32  program counter register.
REQ-010 ir  output  32  instruction register.
REQ-011 aluStart  output  1  one-cycle pulse launching the ALU.
REQ-012 aluValid  input  1  ALU result and flags valid.
REQ-013 aluZero / aluSign / aluCarry  input  1 each  ALU flags, qualified by aluValid.
REQ-014 flagUpdate  input  1  decoder indication that the current ALU instruction writes flags.
REQ-015 brTarget  input  32  branch target from datapath, valid in DECODE.
REQ-016 regWrite  output  1  one-cycle register-file write strobe.
REQ-017 branchTaken  output  1  one-cycle pulse when a branch redirects pc.
REQ-018 halted  output  1  high while in HALT.

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-020 IDLE: stay until start=1, then go to FETCH; start SHALL be ignored in every other state.
REQ-021 FETCH: imemReq=1 and imemAddr=pc held stable until imemAck=1.
REQ-022 On ack, ir SHALL load instr and the next state SHALL be DECODE.
REQ-023 imemReq SHALL be 0 in the cycle after ack, and FETCH SHALL wait indefinitely (no timeout).
REQ-024 DECODE SHALL last exactly one cycle.
REQ-025 In DECODE, opcode 111111 SHALL go to HALT with pc unchanged.
REQ-026 Branch opcodes and their conditions SHALL be:
- 101011 and 101000: unconditional.
- 110001: flagZ=1.
- 110010: flagZ=0.
- 110000: flagS=1.
- 101001: flagC=1.
- 101010: flagC=0.
REQ-027 For a branch opcode in DECODE, if the condition is true then pc <= {brTarget[31:2],2'b00} and branchTaken=1 for that cycle; otherwise pc <= pc+4. The next state SHALL be FETCH in both cases.
REQ-028 Branch conditions SHALL use the registered flags (flagZ, flagS, flagC) only, never the current ALU flag inputs.
REQ-029 For any other opcode in DECODE, aluStart=1 for that one cycle and the next state SHALL be EXEC.
REQ-030 EXEC: wait for aluValid=1; on that cycle, if flagUpdate=1 the registered flags SHALL load aluZero/aluSign/aluCarry; the next state SHALL be WB.
REQ-031 WB: regWrite=1 for one cycle, pc <= pc+4, next state FETCH.
REQ-032 HALT SHALL be absorbing and exit only through reset; halted=1 throughout.
REQ-033 pc arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
REQ-034 aluValid outside EXEC and imemAck outside FETCH SHALL be ignored, with no state or flag change.
REQ-035 aluStart, regWrite and branchTaken SHALL be mutually exclusive, each at most one cycle per instruction.
REQ-036 Instruction latency: non-branch = fetch wait + 1 (DECODE) + ALU wait + 1 (WB); branch = fetch wait + 1.

Reset
REQ-037 While rst=0, the block SHALL hold: state=IDLE, pc=0, ir=0, flagZ=flagS=flagC=0, and all outputs 0.
REQ-038 Reset asserted mid-FETCH SHALL drop imemReq immediately (asynchronously), without waiting for a clock edge.
REQ-039 After rst deasserts, the block SHALL need a new start pulse before fetching.

Verification
REQ-040 Reset, then start=1 for 1 cycle, imemAck 3 cycles later with instr opcode 000000 -> imemReq high 3 cycles; aluStart one cycle after ack; aluValid -> regWrite pulse; pc=4.
REQ-041 ALU instruction with flagUpdate=1 and aluZero=1, then opcode 110001 with brTarget=32'h0000_0103 -> branchTaken=1, pc=32'h0000_0100.
REQ-042 opcode 110010 with flagZ=1 -> no branchTaken, pc advances by 4, next fetch at the old pc+4.
REQ-043 ALU instruction with flagUpdate=0 and aluCarry=1, then opcode 101001 -> not taken (flagC still 0).
REQ-044 Branch to 32'hFFFFFFFC, then an ALU instruction completes -> pc=0. Then opcode 111111 -> halted=1; further imemAck/aluValid/start cause no change.
REQ-045 Assert rst while waiting in FETCH and in EXEC -> all registers return to reset values immediately; after release, no fetch occurs until start.
